// File: rtl/btb_update_sched.sv
`default_nettype none
// ============================================================================
// btb_update_sched : BTB write-side scheduler. Detects mispredictions, queues
//                    updates in a 2-deep FIFO, arbitrates the BTB port, sweeps.
// Revision 1.0
// ============================================================================
module btb_update_sched #(
  parameter int ENTRIES       = 3,
  parameter int TAG_W         = 8,
  parameter int STARVE_LIMIT  = 3,
  localparam int IDX_W        = $clog2(ENTRIES)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush_all,
  input  logic             lookup_req,
  output logic             lookup_stall,
  input  logic             res_valid,
  output logic             res_ready,
  input  logic [31:0]      res_pc,
  input  logic [31:0]      res_target,
  input  logic             res_taken,
  input  logic             res_pred_taken,
  input  logic [31:0]      res_pred_bta,
  input  logic [IDX_W-1:0] res_hit_idx,
  output logic             btb_we,
  output logic [IDX_W-1:0] btb_idx,
  output logic             btb_wvalid,
  output logic [TAG_W-1:0] btb_wtag,
  output logic [31:0]      btb_wbta,
  output logic             mispredict,
  output logic [31:0]      redirect_pc,
  output logic             busy
);

  localparam int               CNT_W      = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(ENTRIES - 1);
  localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);

  typedef enum logic [0:0] {
    CLEAR = 1'b0,
    IDLE  = 1'b1
  } state_t;

  typedef struct packed {
    logic [IDX_W-1:0] idx;
    logic [TAG_W-1:0] tag;
    logic [31:0]      bta;
  } entry_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] sweep_q, sweep_d;
  logic [IDX_W-1:0] victim_q, victim_d;
  logic [CNT_W-1:0] starve_q, starve_d;
  entry_t           fifo_q [2];
  entry_t           head, new_entry;
  logic             rd_ptr_q, wr_ptr_q;
  logic [1:0]       count_q, count_d;
  logic             enq, deq, fifo_clr;
  logic             accept, cond_a, cond_b, cond_c;
  logic             mispredict_q, mispredict_d;
  logic [31:0]      redirect_q, redirect_d;

  assign res_ready = !reset && (state_q == IDLE) && (count_q != 2'd2);
  assign accept    = res_valid && res_ready;

  assign cond_a = res_taken && !res_pred_taken;
  assign cond_b = !res_taken && res_pred_taken;
  assign cond_c = res_taken && res_pred_taken && (res_pred_bta != res_target);

  // Only a missing entry (a) or a stale target (c) needs a BTB write.
  assign enq           = accept && (cond_a || cond_c);
  assign new_entry.idx = cond_a ? victim_q : res_hit_idx;
  assign new_entry.tag = res_pc[TAG_W-1:0];
  assign new_entry.bta = res_target;
  assign head          = fifo_q[rd_ptr_q];
  assign count_d       = count_q + {1'b0, enq} - {1'b0, deq};

  assign mispredict_d = accept && (cond_a || cond_b || cond_c);
  assign redirect_d   = !mispredict_d ? redirect_q :
                        cond_b        ? res_pc + 32'd4 : res_target;

  assign mispredict  = mispredict_q;
  assign redirect_pc = redirect_q;

  always_comb begin
    state_d      = state_q;
    sweep_d      = sweep_q;
    victim_d     = victim_q;
    starve_d     = starve_q;
    deq          = 1'b0;
    fifo_clr     = 1'b0;
    btb_we       = 1'b0;
    btb_idx      = '0;
    btb_wvalid   = 1'b0;
    btb_wtag     = '0;
    btb_wbta     = '0;
    lookup_stall = 1'b0;
    busy         = 1'b0;
    if (!reset) begin
      case (state_q)
        CLEAR: begin
          btb_we       = 1'b1;
          btb_idx      = sweep_q;
          lookup_stall = 1'b1;
          busy         = 1'b1;
          starve_d     = '0;
          if (flush_all) begin
            sweep_d = '0;
          end else if (sweep_q == LAST_IDX) begin
            sweep_d = '0;
            state_d = IDLE;
          end else begin
            sweep_d = sweep_q + 1'b1;
          end
        end
        IDLE: begin
          busy = (count_q != 2'd0);
          if (count_q == 2'd0) begin
            starve_d = '0;
          end else if (!lookup_req) begin
            deq      = 1'b1;
            starve_d = '0;
          end else if (starve_q == STARVE_MAX) begin
            deq          = 1'b1;
            lookup_stall = 1'b1;
            starve_d     = '0;
          end else begin
            starve_d = starve_q + 1'b1;
          end
          if (deq) begin
            btb_we     = 1'b1;
            btb_idx    = head.idx;
            btb_wvalid = 1'b1;
            btb_wtag   = head.tag;
            btb_wbta   = head.bta;
          end
          if (enq && cond_a) begin
            victim_d = (victim_q == LAST_IDX) ? '0 : victim_q + 1'b1;
          end
          if (flush_all) begin
            state_d  = CLEAR;
            sweep_d  = '0;
            victim_d = '0;
            starve_d = '0;
            fifo_clr = 1'b1;
          end
        end
        default: state_d = CLEAR;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= CLEAR;
      sweep_q      <= '0;
      victim_q     <= '0;
      starve_q     <= '0;
      rd_ptr_q     <= 1'b0;
      wr_ptr_q     <= 1'b0;
      count_q      <= 2'd0;
      mispredict_q <= 1'b0;
      redirect_q   <= 32'd0;
    end else begin
      state_q      <= state_d;
      sweep_q      <= sweep_d;
      victim_q     <= victim_d;
      starve_q     <= starve_d;
      mispredict_q <= mispredict_d;
      redirect_q   <= redirect_d;
      if (fifo_clr) begin
        rd_ptr_q <= 1'b0;
        wr_ptr_q <= 1'b0;
        count_q  <= 2'd0;
      end else begin
        if (enq) wr_ptr_q <= ~wr_ptr_q;
        if (deq) rd_ptr_q <= ~rd_ptr_q;
        count_q <= count_d;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (enq) fifo_q[wr_ptr_q] <= new_entry;
  end

endmodule
`default_nettype wire

// File: tb/tb_btb_update_sched.sv
`default_nettype none
// ============================================================================
// tb_btb_update_sched : directed self-checking bench for btb_update_sched.
// Revision 1.0
// ============================================================================
module tb_btb_update_sched;

  logic        clk = 1'b0;
  logic        reset, flush_all, lookup_req, lookup_stall;
  logic        res_valid, res_ready, res_taken, res_pred_taken;
  logic [31:0] res_pc, res_target, res_pred_bta;
  logic [1:0]  res_hit_idx, btb_idx;
  logic        btb_we, btb_wvalid, mispredict, busy;
  logic [7:0]  btb_wtag;
  logic [31:0] btb_wbta, redirect_pc;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  btb_update_sched #(.ENTRIES(3), .TAG_W(8), .STARVE_LIMIT(3)) dut (
    .clk(clk), .reset(reset), .flush_all(flush_all),
    .lookup_req(lookup_req), .lookup_stall(lookup_stall),
    .res_valid(res_valid), .res_ready(res_ready), .res_pc(res_pc),
    .res_target(res_target), .res_taken(res_taken),
    .res_pred_taken(res_pred_taken), .res_pred_bta(res_pred_bta),
    .res_hit_idx(res_hit_idx), .btb_we(btb_we), .btb_idx(btb_idx),
    .btb_wvalid(btb_wvalid), .btb_wtag(btb_wtag), .btb_wbta(btb_wbta),
    .mispredict(mispredict), .redirect_pc(redirect_pc), .busy(busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_res(input logic [31:0] pc, input logic [31:0] tgt,
                           input logic tk, input logic ptk,
                           input logic [31:0] pbta, input logic [1:0] hit);
    res_valid      = 1'b1;
    res_pc         = pc;
    res_target     = tgt;
    res_taken      = tk;
    res_pred_taken = ptk;
    res_pred_bta   = pbta;
    res_hit_idx    = hit;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) tick();
    #1;
    n_chk++;
    if ({btb_we, res_ready, busy, lookup_stall, mispredict} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: we/rdy/busy/stall/mp=%b expected 00000",
               {btb_we, res_ready, busy, lookup_stall, mispredict});
    end
    tick();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #2;
      n_chk++;
      if (btb_we !== 1'b1 || btb_idx !== 2'(i) || btb_wvalid !== 1'b0 ||
          lookup_stall !== 1'b1 || res_ready !== 1'b0 || busy !== 1'b1) begin
        n_fail++;
        $display("FAIL sweep_%0d: we=%b idx=%0d wv=%b stall=%b rdy=%b busy=%b expected 1 %0d 0 1 0 1",
                 i, btb_we, btb_idx, btb_wvalid, lookup_stall, res_ready, busy, i);
      end
      tick();
    end
    #2;
    n_chk++;
    if (busy !== 1'b0 || res_ready !== 1'b1 || btb_we !== 1'b0) begin
      n_fail++;
      $display("FAIL post_sweep_idle: busy=%b rdy=%b we=%b expected 0 1 0", busy, res_ready, btb_we);
    end
    tick();
  endtask

  task automatic test_insert();
    lookup_req = 1'b0;
    drive_res(32'h08, 32'h1100, 1'b1, 1'b0, 32'h0, 2'd0);
    #2;
    n_chk++;
    if (res_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL insert_ready: rdy=%b expected 1", res_ready);
    end
    tick();
    res_valid = 1'b0;
    #2;
    n_chk++;
    if (mispredict !== 1'b1 || redirect_pc !== 32'h1100) begin
      n_fail++;
      $display("FAIL insert_redirect: mp=%b pc=%h expected 1 00001100", mispredict, redirect_pc);
    end
    n_chk++;
    if (btb_we !== 1'b1 || btb_idx !== 2'd0 || btb_wtag !== 8'h08 ||
        btb_wbta !== 32'h1100 || btb_wvalid !== 1'b1) begin
      n_fail++;
      $display("FAIL insert_write: we=%b idx=%0d tag=%h bta=%h wv=%b expected 1 0 08 00001100 1",
               btb_we, btb_idx, btb_wtag, btb_wbta, btb_wvalid);
    end
    tick();
    #2;
    n_chk++;
    if (mispredict !== 1'b0 || redirect_pc !== 32'h1100 || btb_we !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL insert_after: mp=%b pc=%h we=%b busy=%b expected 0 00001100 0 0",
               mispredict, redirect_pc, btb_we, busy);
    end
    tick();
  endtask

  task automatic test_mispredict_kinds();
    drive_res(32'hFFFF_FFFC, 32'h2000, 1'b0, 1'b1, 32'h3000, 2'd1);
    tick();
    res_valid = 1'b0;
    #2;
    n_chk++;
    if (mispredict !== 1'b1 || redirect_pc !== 32'h0 || btb_we !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL not_taken_wrap: mp=%b pc=%h we=%b busy=%b expected 1 00000000 0 0",
               mispredict, redirect_pc, btb_we, busy);
    end
    tick();
    drive_res(32'h100, 32'h700, 1'b1, 1'b1, 32'h700, 2'd1);
    tick();
    res_valid = 1'b0;
    #2;
    n_chk++;
    if (mispredict !== 1'b0 || redirect_pc !== 32'h0 || btb_we !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL correct_pred: mp=%b pc=%h we=%b busy=%b expected 0 00000000 0 0",
               mispredict, redirect_pc, btb_we, busy);
    end
    tick();
    drive_res(32'h1AC, 32'h600, 1'b1, 1'b1, 32'h500, 2'd2);
    tick();
    res_valid = 1'b0;
    #2;
    n_chk++;
    if (mispredict !== 1'b1 || redirect_pc !== 32'h600 || btb_we !== 1'b1 ||
        btb_idx !== 2'd2 || btb_wtag !== 8'hAC || btb_wbta !== 32'h600) begin
      n_fail++;
      $display("FAIL bta_overwrite: mp=%b pc=%h we=%b idx=%0d tag=%h bta=%h expected 1 00000600 1 2 ac 00000600",
               mispredict, redirect_pc, btb_we, btb_idx, btb_wtag, btb_wbta);
    end
    tick();
  endtask

  task automatic test_starvation();
    lookup_req = 1'b1;
    drive_res(32'h20, 32'h4000, 1'b1, 1'b0, 32'h0, 2'd0);
    tick();
    res_valid = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      #2;
      n_chk++;
      if (btb_we !== 1'b0 || lookup_stall !== 1'b0 || busy !== 1'b1) begin
        n_fail++;
        $display("FAIL starve_wait_%0d: we=%b stall=%b busy=%b expected 0 0 1", i, btb_we, lookup_stall, busy);
      end
      tick();
    end
    #2;
    n_chk++;
    if (btb_we !== 1'b1 || lookup_stall !== 1'b1 || btb_idx !== 2'd1 ||
        btb_wtag !== 8'h20 || btb_wbta !== 32'h4000) begin
      n_fail++;
      $display("FAIL starve_win: we=%b stall=%b idx=%0d tag=%h bta=%h expected 1 1 1 20 00004000",
               btb_we, lookup_stall, btb_idx, btb_wtag, btb_wbta);
    end
    tick();
    #2;
    n_chk++;
    if (btb_we !== 1'b0 || lookup_stall !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL starve_after: we=%b stall=%b busy=%b expected 0 0 0", btb_we, lookup_stall, busy);
    end
    tick();
  endtask

  task automatic test_full_queue();
    lookup_req = 1'b1;
    drive_res(32'h30, 32'h5000, 1'b1, 1'b0, 32'h0, 2'd0);
    tick();
    drive_res(32'h34, 32'h5100, 1'b1, 1'b0, 32'h0, 2'd0);
    #2;
    n_chk++;
    if (res_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL full_second_accept: rdy=%b expected 1", res_ready);
    end
    tick();
    drive_res(32'h38, 32'h5200, 1'b1, 1'b0, 32'h0, 2'd0);
    for (int i = 0; i < 2; i++) begin
      #2;
      n_chk++;
      if (res_ready !== 1'b0 || btb_we !== 1'b0) begin
        n_fail++;
        $display("FAIL full_blocked_%0d: rdy=%b we=%b expected 0 0", i, res_ready, btb_we);
      end
      tick();
    end
    #2;
    n_chk++;
    if (btb_we !== 1'b1 || btb_idx !== 2'd2 || btb_wbta !== 32'h5000 ||
        lookup_stall !== 1'b1 || res_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL full_starve_deq: we=%b idx=%0d bta=%h stall=%b rdy=%b expected 1 2 00005000 1 0",
               btb_we, btb_idx, btb_wbta, lookup_stall, res_ready);
    end
    tick();
    #2;
    n_chk++;
    if (res_ready !== 1'b1 || btb_we !== 1'b0) begin
      n_fail++;
      $display("FAIL full_third_accept: rdy=%b we=%b expected 1 0", res_ready, btb_we);
    end
    tick();
    res_valid  = 1'b0;
    lookup_req = 1'b0;
    #2;
    n_chk++;
    if (btb_we !== 1'b1 || btb_idx !== 2'd0 || btb_wbta !== 32'h5100 || btb_wtag !== 8'h34) begin
      n_fail++;
      $display("FAIL full_drain_b: we=%b idx=%0d bta=%h tag=%h expected 1 0 00005100 34",
               btb_we, btb_idx, btb_wbta, btb_wtag);
    end
    tick();
    #2;
    n_chk++;
    if (btb_we !== 1'b1 || btb_idx !== 2'd1 || btb_wbta !== 32'h5200 || btb_wtag !== 8'h38) begin
      n_fail++;
      $display("FAIL full_drain_c: we=%b idx=%0d bta=%h tag=%h expected 1 1 00005200 38",
               btb_we, btb_idx, btb_wbta, btb_wtag);
    end
    tick();
    #2;
    n_chk++;
    if (btb_we !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL full_empty: we=%b busy=%b expected 0 0", btb_we, busy);
    end
    tick();
  endtask

  task automatic test_flush();
    lookup_req = 1'b1;
    drive_res(32'h50, 32'h6000, 1'b1, 1'b0, 32'h0, 2'd0);
    tick();
    drive_res(32'h54, 32'h6100, 1'b1, 1'b0, 32'h0, 2'd0);
    tick();
    res_valid = 1'b0;
    flush_all = 1'b1;
    #2;
    n_chk++;
    if (btb_we !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_cycle: we=%b busy=%b expected 0 1", btb_we, busy);
    end
    tick();
    flush_all  = 1'b0;
    lookup_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #2;
      n_chk++;
      if (btb_we !== 1'b1 || btb_idx !== 2'(i) || btb_wvalid !== 1'b0 ||
          lookup_stall !== 1'b1 || res_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL flush_sweep_%0d: we=%b idx=%0d wv=%b stall=%b rdy=%b expected 1 %0d 0 1 0",
                 i, btb_we, btb_idx, btb_wvalid, lookup_stall, res_ready, i);
      end
      tick();
    end
    for (int i = 0; i < 2; i++) begin
      #2;
      n_chk++;
      if (btb_we !== 1'b0 || busy !== 1'b0 || res_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL flush_no_stale_%0d: we=%b busy=%b rdy=%b expected 0 0 1", i, btb_we, busy, res_ready);
      end
      tick();
    end
    drive_res(32'h70, 32'h7000, 1'b1, 1'b0, 32'h0, 2'd0);
    tick();
    res_valid = 1'b0;
    #2;
    n_chk++;
    if (btb_we !== 1'b1 || btb_idx !== 2'd0 || btb_wbta !== 32'h7000) begin
      n_fail++;
      $display("FAIL flush_ptr_reset: we=%b idx=%0d bta=%h expected 1 0 00007000", btb_we, btb_idx, btb_wbta);
    end
    tick();
  endtask

  task automatic test_flush_in_clear();
    flush_all = 1'b1;
    tick();
    flush_all = 1'b0;
    tick();
    flush_all = 1'b1;
    #2;
    n_chk++;
    if (btb_we !== 1'b1 || btb_idx !== 2'd1) begin
      n_fail++;
      $display("FAIL clear_mid: we=%b idx=%0d expected 1 1", btb_we, btb_idx);
    end
    tick();
    flush_all = 1'b0;
    #2;
    n_chk++;
    if (btb_we !== 1'b1 || btb_idx !== 2'd0 || lookup_stall !== 1'b1) begin
      n_fail++;
      $display("FAIL clear_restart: we=%b idx=%0d stall=%b expected 1 0 1", btb_we, btb_idx, lookup_stall);
    end
    repeat (3) tick();
    #2;
    n_chk++;
    if (busy !== 1'b0 || res_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL clear_done: busy=%b rdy=%b expected 0 1", busy, res_ready);
    end
    tick();
  endtask

  initial begin
    reset          = 1'b1;
    flush_all      = 1'b0;
    lookup_req     = 1'b0;
    res_valid      = 1'b0;
    res_pc         = 32'h0;
    res_target     = 32'h0;
    res_taken      = 1'b0;
    res_pred_taken = 1'b0;
    res_pred_bta   = 32'h0;
    res_hit_idx    = 2'd0;
    test_reset();
    test_insert();
    test_mispredict_kinds();
    test_starvation();
    test_full_queue();
    test_flush();
    test_flush_in_clear();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
